asgn_op_sequencer: RTL and testbench
====================================

Name: asgn_op_sequencer

Overview:
Command-driven sequencer for a small integer register file (x, y, z) that executes SystemVerilog assignment-expression operations: pre/post increment/decrement and compound assignments. Each command returns the value the equivalent expression yields. Multiply is iterative and multi-cycle; all other ops complete in one cycle. It is the control/sequencing shell around the assignment-expression datapath exercised by the frontend tests.

Parameters:
WIDTH, 32, register and data width (two's complement)
NREG, 3, number of registers (x=0, y=1, z=2); index 3 is illegal

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  sequencer can accept a command
cmd_op  in  4  operation code
cmd_dst  in  2  destination register index
cmd_src  in  2  source register index for rhs
cmd_use_imm  in  1  1: rhs = cmd_imm; 0: rhs = reg[cmd_src]
cmd_imm  in  WIDTH  immediate rhs
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed
rsp_data  out  WIDTH  expression value
rsp_err  out  1  illegal op or register index
rd_addr  in  2  debug read index
rd_data  out  WIDTH  committed reg[rd_addr], combinational; 0 for index 3

Behaviour:
- Reset (async, rst_n=0): x=y=z=0, state IDLE, cmd_ready=1, rsp_valid=0, rsp_data=0, rsp_err=0, multiplier cleared; any in-flight command is dropped.
- Op codes, with result value in parentheses:
  0 ASSIGN dst=rhs (new value)
  1 PREINC, 2 PREDEC (new value)
  3 POSTINC, 4 POSTDEC (old value)
  5 +=, 6 -= (new value)
  7 *= (new value, multi-cycle)
  8 >>= logical, 9 <<=, 10 >>>= arithmetic (new value)
  11-15 illegal
- Operands are snapshotted at accept, so dst==src uses the old value (x *= x squares the old x). rhs is ignored for ops 1-4.
- Arithmetic: all results wrap modulo 2^WIDTH. *= keeps the low WIDTH bits. The shift amount is rhs treated as unsigned; an amount >= WIDTH gives 0 for >>= and <<=, and sign-fill for >>>=.
- Error: illegal op, or dst==3, or (cmd_use_imm==0 and src==3) gives rsp_err=1, rsp_data=0, and no register change. Reported with single-cycle latency.
- FSM:
  - IDLE: cmd_ready=1. Handshake is cmd_valid && cmd_ready at a rising edge.
    - Single-cycle op: register write and rsp_valid=1 at that same edge; go to RESP.
    - Op 7: go to MUL.
  - MUL: cmd_ready=0. Radix-2 shift-add, one bit per cycle, WIDTH cycles. At the final edge, write dst, set rsp_valid, go to RESP. rsp_valid rises exactly WIDTH edges after accept.
  - RESP: rsp_valid=1, cmd_ready=0. rsp_data/rsp_err are held stable until rsp_valid && rsp_ready; then rsp_valid=0 and go to IDLE.
- No bypass from RESP to accept: maximum throughput is one simple command per 2 cycles.
- cmd_valid while cmd_ready=0 is ignored; the source must hold it.
- rd_data reflects a write from the edge after that write.

Test Plan:
1. Reset; POSTINC x -> rsp 0, rd x=1. PREDEC x -> rsp 0. POSTDEC z -> rsp 0, z=-1. PREINC z -> rsp 0.
2. ASSIGN z imm 99 -> 99. ASSIGN y src z -> 99. += y imm 1 -> 100. *= y imm 2 -> rsp_valid exactly 32 edges after accept, rsp 200. *= x src x with x=-3 -> 9.
3. z=99: >>= imm 2 -> 24. >>= imm 32'hFFFFFFFF -> 0 (unsigned amount). z=-8: >>>= imm 1 -> -4. >>>= imm 40 -> -1. <<= imm 31 on 3 -> 32'h80000000.
4. Wrap: ASSIGN x 32'h7FFFFFFF; PREINC -> 32'h80000000. POSTDEC -> rsp 32'h80000000, x=32'h7FFFFFFF. -= imm 1 on 32'h80000000 -> 32'h7FFFFFFF.
5. Backpressure: hold rsp_ready=0 for 5 cycles -> rsp_valid/rsp_data stable, cmd_ready=0, a concurrent cmd_valid is not accepted and no register change occurs. Then rsp_ready=1 -> IDLE next edge.
6. Errors/reset: op 12 -> rsp_err=1, data 0, regs unchanged. dst=3 -> rsp_err=1. Assert rst_n in MUL cycle 10 -> rsp_valid=0 immediately, regs 0, cmd_ready=1 after release, no response emitted.

Source files
------------

// File: rtl/asgn_op_sequencer_if.sv
// Command/response handshake bundle for the assignment-expression sequencer.
interface asgn_op_sequencer_if #(
  parameter int unsigned WIDTH = 32
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [3:0]       cmd_op;
  logic [1:0]       cmd_dst;
  logic [1:0]       cmd_src;
  logic             cmd_use_imm;
  logic [WIDTH-1:0] cmd_imm;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_dst, cmd_src, cmd_use_imm, cmd_imm, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_dst, cmd_src, cmd_use_imm, cmd_imm, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/asgn_op_sequencer.sv
// Sequencer executing SV assignment-expression ops on a tiny register file.
// Simple ops finish at the accept edge; *= runs a radix-2 shift-add over WIDTH cycles.
module asgn_op_sequencer #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NREG  = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  asgn_op_sequencer_if.slave    bus,
  input  logic [1:0]            rd_addr,
  output logic [WIDTH-1:0]      rd_data
);
  localparam int unsigned SHW = $clog2(WIDTH);
  localparam int unsigned CW  = $clog2(WIDTH);

  localparam logic [3:0] OP_ASSIGN  = 4'd0;
  localparam logic [3:0] OP_PREINC  = 4'd1;
  localparam logic [3:0] OP_PREDEC  = 4'd2;
  localparam logic [3:0] OP_POSTINC = 4'd3;
  localparam logic [3:0] OP_POSTDEC = 4'd4;
  localparam logic [3:0] OP_ADD     = 4'd5;
  localparam logic [3:0] OP_SUB     = 4'd6;
  localparam logic [3:0] OP_MUL     = 4'd7;
  localparam logic [3:0] OP_SHR     = 4'd8;
  localparam logic [3:0] OP_SHL     = 4'd9;
  localparam logic [3:0] OP_ASR     = 4'd10;

  typedef enum logic [1:0] {IDLE, MUL, RESP} state_t;

  state_t           state;
  logic [WIDTH-1:0] regs [NREG];
  logic             ready;
  logic             resp_valid;
  logic [WIDTH-1:0] resp_data;
  logic             resp_err;
  logic [WIDTH-1:0] mul_acc;
  logic [WIDTH-1:0] mul_mcand;
  logic [WIDTH-1:0] mul_mplier;
  logic [CW-1:0]    mul_cnt;
  logic [1:0]       mul_dst;

  logic             dst_ok;
  logic             src_ok;
  logic             illegal;
  logic             big_shift;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] lhs;
  logic [WIDTH-1:0] rhs;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] mul_sum;

  assign bus.cmd_ready = ready;
  assign bus.rsp_valid = resp_valid;
  assign bus.rsp_data  = resp_data;
  assign bus.rsp_err   = resp_err;

  assign rd_data = (32'(rd_addr) < NREG) ? regs[rd_addr] : '0;

  // Operand snapshot and single-cycle result for the command currently offered.
  always_comb begin
    dst_ok    = 32'(bus.cmd_dst) < NREG;
    src_ok    = 32'(bus.cmd_src) < NREG;
    lhs       = dst_ok ? regs[bus.cmd_dst] : '0;
    rhs       = bus.cmd_use_imm ? bus.cmd_imm : (src_ok ? regs[bus.cmd_src] : '0);
    illegal   = (bus.cmd_op > OP_ASR) || !dst_ok || (!bus.cmd_use_imm && !src_ok);
    big_shift = 64'(rhs) >= 64'(WIDTH);
    shamt     = rhs[SHW-1:0];
    result    = '0;
    case (bus.cmd_op)
      OP_ASSIGN:  result = rhs;
      OP_PREINC:  result = lhs + WIDTH'(1);
      OP_PREDEC:  result = lhs - WIDTH'(1);
      OP_POSTINC: result = lhs;
      OP_POSTDEC: result = lhs;
      OP_ADD:     result = lhs + rhs;
      OP_SUB:     result = lhs - rhs;
      OP_SHR:     result = big_shift ? '0 : (lhs >> shamt);
      OP_SHL:     result = big_shift ? '0 : (lhs << shamt);
      OP_ASR:     result = big_shift ? {WIDTH{lhs[WIDTH-1]}}
                                     : WIDTH'($signed(lhs) >>> shamt);
      default:    result = '0;
    endcase
  end

  assign mul_sum = mul_acc + (mul_mplier[0] ? mul_mcand : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ready      <= 1'b1;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
      mul_acc    <= '0;
      mul_mcand  <= '0;
      mul_mplier <= '0;
      mul_cnt    <= '0;
      mul_dst    <= '0;
      for (int i = 0; i < int'(NREG); i++) regs[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            ready <= 1'b0;
            if (illegal) begin
              resp_valid <= 1'b1;
              resp_data  <= '0;
              resp_err   <= 1'b1;
              state      <= RESP;
            end else if (bus.cmd_op == OP_MUL) begin
              mul_acc    <= '0;
              mul_mcand  <= lhs;
              mul_mplier <= rhs;
              mul_cnt    <= '0;
              mul_dst    <= bus.cmd_dst;
              state      <= MUL;
            end else begin
              regs[bus.cmd_dst] <= (bus.cmd_op == OP_POSTINC) ? lhs + WIDTH'(1) :
                                   (bus.cmd_op == OP_POSTDEC) ? lhs - WIDTH'(1) : result;
              resp_valid <= 1'b1;
              resp_data  <= result;
              resp_err   <= 1'b0;
              state      <= RESP;
            end
          end
        end
        // One multiplier bit per edge; the last edge commits the product.
        MUL: begin
          mul_acc    <= mul_sum;
          mul_mcand  <= mul_mcand << 1;
          mul_mplier <= mul_mplier >> 1;
          mul_cnt    <= mul_cnt + CW'(1);
          if (mul_cnt == CW'(WIDTH - 1)) begin
            regs[mul_dst] <= mul_sum;
            resp_valid    <= 1'b1;
            resp_data     <= mul_sum;
            resp_err      <= 1'b0;
            state         <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            resp_valid <= 1'b0;
            ready      <= 1'b1;
            state      <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_asgn_op_sequencer.sv
// Directed bench for asgn_op_sequencer with hand-computed expected values.
module tb_asgn_op_sequencer;
  logic        clk;
  logic        rst_n;
  logic [1:0]  rd_addr;
  logic [31:0] rd_data;
  int          passed;
  int          total;

  asgn_op_sequencer_if #(.WIDTH(32)) bus ();

  asgn_op_sequencer #(.WIDTH(32), .NREG(3)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic chk_reg(input logic [1:0] idx, input logic [31:0] exp, input string tag);
    rd_addr = idx;
    #1;
    check(tag, rd_data, exp);
  endtask

  task automatic send(input logic [3:0] op, input logic [1:0] dst, input logic [1:0] src,
                      input logic ui, input logic [31:0] imm);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    bus.cmd_op      = op;
    bus.cmd_dst     = dst;
    bus.cmd_src     = src;
    bus.cmd_use_imm = ui;
    bus.cmd_imm     = imm;
    bus.cmd_valid   = 1'b1;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag, output int edges);
    edges = 0;
    while (!bus.rsp_valid && edges < 100) begin
      @(posedge clk);
      #1;
      edges++;
    end
    if (!bus.rsp_valid) check({tag, ".timeout"}, 32'(bus.rsp_valid), 32'd1);
  endtask

  task automatic release_rsp(input string tag);
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    check({tag, ".idle"}, {30'd0, bus.rsp_valid, bus.cmd_ready}, 32'd1);
  endtask

  task automatic do_cmd(input logic [3:0] op, input logic [1:0] dst, input logic [1:0] src,
                        input logic ui, input logic [31:0] imm,
                        input logic [31:0] exp_d, input logic exp_e, input string tag);
    int edges;
    send(op, dst, src, ui, imm);
    wait_rsp(tag, edges);
    check({tag, ".data"}, bus.rsp_data, exp_d);
    check({tag, ".err"}, 32'(bus.rsp_err), 32'(exp_e));
    release_rsp(tag);
  endtask

  initial begin
    int edges;
    passed = 0;
    total  = 0;
    rd_addr = 2'd0;
    bus.cmd_valid = 1'b0; bus.cmd_op = 4'd0; bus.cmd_dst = 2'd0; bus.cmd_src = 2'd0;
    bus.cmd_use_imm = 1'b0; bus.cmd_imm = 32'd0; bus.rsp_ready = 1'b0;
    rst_n = 1'b0;
    #12;
    check("rst.ready", 32'(bus.cmd_ready), 32'd1);
    check("rst.valid", 32'(bus.rsp_valid), 32'd0);
    check("rst.data",  bus.rsp_data, 32'd0);
    check("rst.err",   32'(bus.rsp_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Increment / decrement forms
    do_cmd(4'd3, 2'd0, 2'd0, 1'b1, 32'd0, 32'd0, 1'b0, "postinc_x");
    chk_reg(2'd0, 32'd1, "x_after_postinc");
    do_cmd(4'd2, 2'd0, 2'd0, 1'b1, 32'd0, 32'd0, 1'b0, "predec_x");
    do_cmd(4'd4, 2'd2, 2'd0, 1'b1, 32'd0, 32'd0, 1'b0, "postdec_z");
    chk_reg(2'd2, 32'hFFFF_FFFF, "z_after_postdec");
    do_cmd(4'd1, 2'd2, 2'd0, 1'b1, 32'd0, 32'd0, 1'b0, "preinc_z");

    // Assign, add, multiply
    do_cmd(4'd0, 2'd2, 2'd0, 1'b1, 32'd99, 32'd99, 1'b0, "assign_z");
    do_cmd(4'd0, 2'd1, 2'd2, 1'b0, 32'd0, 32'd99, 1'b0, "assign_y_z");
    do_cmd(4'd5, 2'd1, 2'd0, 1'b1, 32'd1, 32'd100, 1'b0, "add_y");
    send(4'd7, 2'd1, 2'd0, 1'b1, 32'd2);
    check("mul.busy", 32'(bus.cmd_ready), 32'd0);
    wait_rsp("mul_y", edges);
    check("mul.latency", 32'(edges), 32'd32);
    check("mul.data", bus.rsp_data, 32'd200);
    release_rsp("mul_y");
    do_cmd(4'd0, 2'd0, 2'd0, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 1'b0, "assign_x_m3");
    do_cmd(4'd7, 2'd0, 2'd0, 1'b0, 32'd0, 32'd9, 1'b0, "mul_x_x");
    chk_reg(2'd0, 32'd9, "x_squared");

    // Shifts
    do_cmd(4'd8, 2'd2, 2'd0, 1'b1, 32'd2, 32'd24, 1'b0, "shr_2");
    do_cmd(4'd8, 2'd2, 2'd0, 1'b1, 32'hFFFF_FFFF, 32'd0, 1'b0, "shr_big");
    do_cmd(4'd0, 2'd2, 2'd0, 1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFF8, 1'b0, "assign_z_m8");
    do_cmd(4'd10, 2'd2, 2'd0, 1'b1, 32'd1, 32'hFFFF_FFFC, 1'b0, "asr_1");
    do_cmd(4'd10, 2'd2, 2'd0, 1'b1, 32'd40, 32'hFFFF_FFFF, 1'b0, "asr_40");
    do_cmd(4'd0, 2'd2, 2'd0, 1'b1, 32'd3, 32'd3, 1'b0, "assign_z_3");
    do_cmd(4'd9, 2'd2, 2'd0, 1'b1, 32'd31, 32'h8000_0000, 1'b0, "shl_31");
    do_cmd(4'd9, 2'd2, 2'd0, 1'b1, 32'd32, 32'd0, 1'b0, "shl_32");

    // Wraparound
    do_cmd(4'd0, 2'd0, 2'd0, 1'b1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, "assign_x_max");
    do_cmd(4'd1, 2'd0, 2'd0, 1'b1, 32'd0, 32'h8000_0000, 1'b0, "preinc_wrap");
    do_cmd(4'd4, 2'd0, 2'd0, 1'b1, 32'd0, 32'h8000_0000, 1'b0, "postdec_wrap");
    chk_reg(2'd0, 32'h7FFF_FFFF, "x_after_postdec_wrap");
    do_cmd(4'd0, 2'd0, 2'd0, 1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0, "assign_x_min");
    do_cmd(4'd6, 2'd0, 2'd0, 1'b1, 32'd1, 32'h7FFF_FFFF, 1'b0, "sub_wrap");

    // Response backpressure with a competing command held on the bus
    send(4'd0, 2'd1, 2'd0, 1'b1, 32'd5);
    @(negedge clk);
    bus.cmd_op = 4'd0; bus.cmd_dst = 2'd1; bus.cmd_use_imm = 1'b1; bus.cmd_imm = 32'd77;
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp.valid", 32'(bus.rsp_valid), 32'd1);
      check("bp.data", bus.rsp_data, 32'd5);
      check("bp.ready", 32'(bus.cmd_ready), 32'd0);
    end
    chk_reg(2'd1, 32'd5, "bp.y_unchanged");
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    release_rsp("bp");

    // Error responses
    do_cmd(4'd12, 2'd0, 2'd0, 1'b1, 32'd1, 32'd0, 1'b1, "err_op12");
    chk_reg(2'd0, 32'h7FFF_FFFF, "err_x_unchanged");
    do_cmd(4'd0, 2'd3, 2'd0, 1'b1, 32'd5, 32'd0, 1'b1, "err_dst3");
    do_cmd(4'd5, 2'd1, 2'd3, 1'b0, 32'd0, 32'd0, 1'b1, "err_src3");
    chk_reg(2'd1, 32'd5, "err_y_unchanged");
    chk_reg(2'd3, 32'd0, "rd_idx3");

    // Reset in the middle of a multiply
    send(4'd7, 2'd0, 2'd0, 1'b1, 32'd3);
    for (int i = 0; i < 9; i++) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mrst.valid", 32'(bus.rsp_valid), 32'd0);
    check("mrst.ready", 32'(bus.cmd_ready), 32'd1);
    chk_reg(2'd0, 32'd0, "mrst.x");
    chk_reg(2'd1, 32'd0, "mrst.y");
    chk_reg(2'd2, 32'd0, "mrst.z");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.rsp_valid) check("mrst.no_rsp", 32'(bus.rsp_valid), 32'd0);
    end
    check("mrst.ready_after", 32'(bus.cmd_ready), 32'd1);
    chk_reg(2'd0, 32'd0, "mrst.x_after");
    do_cmd(4'd1, 2'd1, 2'd0, 1'b1, 32'd0, 32'd1, 1'b0, "post_reset_preinc");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
